// File: rtl/fabric_cfg_pkg.sv
// Shared constants and state encoding for the fabric configuration sequencer.
package fabric_cfg_pkg;

  localparam logic [31:0] SyncWord   = 32'hFAB0FAB1;
  localparam logic [31:0] DesyncWord = 32'hFAB0FAB0;

  // Header word layout: [31:28] marker, [15:8] column, [7:0] frame.
  localparam logic [3:0]  HdrMarker   = 4'h8;
  localparam int unsigned HdrTagLsb   = 28;
  localparam int unsigned HdrColLsb   = 8;
  localparam int unsigned HdrFrameLsb = 0;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StData,
    StStrobe
  } cfg_state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a latched column/frame address into a registered one-hot FrameStrobe pulse,
// and range-checks incoming header addresses.
module frame_strobe_decoder
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned NUM_COLUMNS = 10,
  parameter int unsigned MAX_FRAMES  = 20
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [7:0]                        chk_col,
  input  logic [7:0]                        chk_frame,
  output logic                              chk_ok,
  input  logic [7:0]                        col,
  input  logic [7:0]                        frame,
  input  logic                              fire,
  input  logic                              drop,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] strobe
);

  localparam int unsigned NumStrobes = NUM_COLUMNS * MAX_FRAMES;

  logic [NumStrobes-1:0] strobe_d, strobe_q;
  logic                  addr_ok;
  logic [31:0]           idx;

  always_comb begin
    chk_ok = ({24'b0, chk_col} < NUM_COLUMNS) && ({24'b0, chk_frame} < MAX_FRAMES);
  end

  // The range recheck keeps an out-of-range address from aliasing onto another column.
  always_comb begin
    strobe_d = '0;
    addr_ok  = ({24'b0, col} < NUM_COLUMNS) && ({24'b0, frame} < MAX_FRAMES);
    idx      = {24'b0, col} * MAX_FRAMES + {24'b0, frame};
    for (int unsigned i = 0; i < NumStrobes; i++) begin
      strobe_d[i] = fire && !drop && addr_ok && (idx == i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream-to-frame sequencer: assembles NUM_ROWS-word frames from a valid/ready word
// stream and issues one-hot FrameStrobe load pulses per column/frame.
module frame_config_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = 8,
  parameter int unsigned NUM_COLUMNS = 10,
  parameter int unsigned MAX_FRAMES  = 20,
  parameter logic [31:0] SYNC_WORD   = SyncWord,
  parameter logic [31:0] DESYNC_WORD = DesyncWord
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [31:0]                       s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [32*NUM_ROWS-1:0]            FrameData,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] FrameStrobe,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int unsigned    RowW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NUM_ROWS - 1);

  cfg_state_e             state_d, state_q;
  logic [RowW-1:0]        row_d, row_q;
  logic [7:0]             col_d, col_q;
  logic [7:0]             frame_d, frame_q;
  logic                   drop_d, drop_q;
  logic [32*NUM_ROWS-1:0] fd_d, fd_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;
  logic                   error_d, error_q;
  logic                   xfer, fire, hdr_ok, is_hdr;

  // s_ready depends only on registered state, never on s_valid.
  assign s_ready = (state_q != StStrobe);
  assign xfer    = s_valid && s_ready;
  assign is_hdr  = (s_data[HdrTagLsb +: 4] == HdrMarker);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    fd_d    = fd_q;
    busy_d  = busy_q;
    error_d = error_q;
    done_d  = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer && (s_data == SYNC_WORD)) begin
          state_d = StHeader;
          busy_d  = 1'b1;
          error_d = 1'b0;
        end
      end
      StHeader: begin
        if (xfer) begin
          if (s_data == DESYNC_WORD) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (is_hdr) begin
            col_d   = s_data[HdrColLsb +: 8];
            frame_d = s_data[HdrFrameLsb +: 8];
            drop_d  = !hdr_ok;
            row_d   = '0;
            state_d = StData;
            if (!hdr_ok) error_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StData: begin
        if (xfer) begin
          for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (row_q == RowW'(r)) fd_d[32*r +: 32] = s_data;
          end
          if (row_q == LastRow) begin
            state_d = StStrobe;
            fire    = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StStrobe: begin
        row_d   = '0;
        state_d = StHeader;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      drop_q  <= 1'b0;
      fd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  frame_strobe_decoder #(
    .NUM_COLUMNS(NUM_COLUMNS),
    .MAX_FRAMES (MAX_FRAMES)
  ) u_strobe_dec (
    .CLK      (CLK),
    .RST      (RST),
    .chk_col  (s_data[HdrColLsb +: 8]),
    .chk_frame(s_data[HdrFrameLsb +: 8]),
    .chk_ok   (hdr_ok),
    .col      (col_q),
    .frame    (frame_q),
    .fire     (fire),
    .drop     (drop_q),
    .strobe   (FrameStrobe)
  );

  assign FrameData = fd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: frames, drops, header errors, gaps, mid-frame reset.
module tb_frame_config_sequencer;

  logic         CLK = 1'b0;
  logic         RST;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] FrameData;
  logic [199:0] FrameStrobe;
  logic         busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int rdy_low_cnt = 0;
  logic [199:0] last_strobe = '0;
  logic [255:0] last_fd = '0;
  bit gaps = 1'b0;
  int s0, d0, r0;

  frame_config_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] onehot(input int i);
    return 256'(1) << i;
  endfunction

  function automatic logic [31:0] row_word(input logic [31:0] seed, input int k);
    return seed * 32'(k + 1);
  endfunction

  function automatic logic [255:0] exp_fd(input logic [31:0] seed);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = row_word(seed, k);
    return v;
  endfunction

  // Observe away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (FrameStrobe != '0) begin
        strobe_cnt++;
        last_strobe = FrameStrobe;
        last_fd = FrameData;
        check("strobe_onehot", 256'($countones(FrameStrobe)), 256'd1);
        check("ready_low_in_strobe", 256'(s_ready), 256'd0);
        check("no_done_with_strobe", 256'(done), 256'd0);
      end
      if (done) done_cnt++;
      if (!s_ready) rdy_low_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    int guard;
    guard = 0;
    if (gaps) begin
      while (($urandom_range(0, 1) == 1) && (guard < 8)) begin
        s_valid = 1'b0;
        tick();
        guard++;
      end
    end
    guard = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && (guard < 10)) begin
      tick();
      guard++;
    end
    if (!s_ready) check("ready_timeout", 256'(s_ready), 256'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] seed);
    push(hdr);
    for (int k = 0; k < 8; k++) push(row_word(seed, k));
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    s_valid = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    do_reset();

    // Reset state
    check("rst_ready", 256'(s_ready), 256'd1);
    check("rst_framedata", FrameData, 256'd0);
    check("rst_strobe", 256'(FrameStrobe), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_error", 256'(error), 256'd0);

    // Words before SYNC are dropped
    push(32'hDEADBEEF);
    push(32'hFAB0FAB0);
    tick();
    check("pre_sync_strobes", 256'(strobe_cnt), 256'd0);
    check("pre_sync_busy", 256'(busy), 256'd0);
    check("pre_sync_error", 256'(error), 256'd0);
    check("pre_sync_done", 256'(done_cnt), 256'd0);

    // Basic frame col 3 frame 5 -> bit 65
    s0 = strobe_cnt;
    d0 = done_cnt;
    push(32'hFAB0FAB1);
    check("sync_busy", 256'(busy), 256'd1);
    send_frame(32'h8000_0305, 32'h11);
    check("strobe_latency", 256'(FrameStrobe), onehot(65));
    push(32'hFAB0FAB0);
    tick();
    tick();
    check("c1_strobe_cnt", 256'(strobe_cnt - s0), 256'd1);
    check("c1_strobe_bit", 256'(last_strobe), onehot(65));
    check("c1_framedata", last_fd, exp_fd(32'h11));
    check("c1_done_cnt", 256'(done_cnt - d0), 256'd1);
    check("c1_busy", 256'(busy), 256'd0);
    check("c1_error", 256'(error), 256'd0);
    check("c1_strobe_idle", 256'(FrameStrobe), 256'd0);

    // Out-of-range column is dropped; next valid frame strobes, error stays sticky
    push(32'hFAB0FAB1);
    s0 = strobe_cnt;
    send_frame(32'h8000_0A00, 32'h22);
    tick();
    check("c3_drop_no_strobe", 256'(strobe_cnt - s0), 256'd0);
    check("c3_error_set", 256'(error), 256'd1);
    send_frame(32'h8000_0100, 32'h0101_0101);
    tick();
    check("c3_strobe_cnt", 256'(strobe_cnt - s0), 256'd1);
    check("c3_strobe_bit", 256'(last_strobe), onehot(20));
    check("c3_framedata", last_fd, exp_fd(32'h0101_0101));
    check("c3_error_sticky", 256'(error), 256'd1);
    push(32'hFAB0FAB0);

    // SYNC clears error; junk header word sets it and resyncs on next header
    push(32'hFAB0FAB1);
    check("c4_sync_clears_error", 256'(error), 256'd0);
    push(32'h1234_5678);
    check("c4_bad_hdr_error", 256'(error), 256'd1);
    s0 = strobe_cnt;
    send_frame(32'h8000_0305, 32'h44);
    tick();
    check("c4_strobe_cnt", 256'(strobe_cnt - s0), 256'd1);
    check("c4_strobe_bit", 256'(last_strobe), onehot(65));
    check("c4_framedata", last_fd, exp_fd(32'h44));
    push(32'hFAB0FAB0);

    // Random valid gaps: same result as the basic frame, ready low only in STROBE
    push(32'hFAB0FAB1);
    gaps = 1'b1;
    s0 = strobe_cnt;
    r0 = rdy_low_cnt;
    send_frame(32'h8000_0305, 32'h11);
    tick();
    tick();
    gaps = 1'b0;
    check("c5_strobe_cnt", 256'(strobe_cnt - s0), 256'd1);
    check("c5_strobe_bit", 256'(last_strobe), onehot(65));
    check("c5_framedata", last_fd, exp_fd(32'h11));
    check("c5_ready_low_cycles", 256'(rdy_low_cnt - r0), 256'd1);
    push(32'hFAB0FAB0);

    // Reset after four data words aborts the frame
    push(32'hFAB0FAB1);
    s0 = strobe_cnt;
    push(32'h8000_0305);
    for (int k = 0; k < 4; k++) push(row_word(32'h66, k));
    do_reset();
    tick();
    tick();
    check("c6_no_strobe", 256'(strobe_cnt - s0), 256'd0);
    check("c6_framedata", FrameData, 256'd0);
    check("c6_busy", 256'(busy), 256'd0);
    check("c6_ready", 256'(s_ready), 256'd1);
    push(32'hFAB0FAB1);
    send_frame(32'h8000_0100, 32'h55);
    push(32'hFAB0FAB0);
    tick();
    check("c6_new_strobe_cnt", 256'(strobe_cnt - s0), 256'd1);
    check("c6_new_strobe_bit", 256'(last_strobe), onehot(20));
    check("c6_new_framedata", last_fd, exp_fd(32'h55));
    check("c6_new_error", 256'(error), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
